// File: rtl/adder_rr_scheduler.sv
// Round-robin shared adder: NREQ requesters feed one LAT-deep sum pipeline,
// results are tagged with the issuing requester id; output backpressure stalls everything.
module adder_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH:0]            rsp_sum,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           vld_q [LAT];
    logic [IDW-1:0] id_q  [LAT];
    logic [WIDTH:0] sum_q [LAT];

    logic           adv;
    logic           found;
    logic           xfer;
    logic [IDW-1:0] win;
    int             scan_idx;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   sum_s;

    assign adv = !rsp_valid || rsp_ready;

    // Rotating priority search starting at ptr_q
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                win   = IDW'(scan_idx);
            end
        end
    end

    assign xfer      = found && adv;
    assign req_ready = xfer ? (NREQ'(1) << win) : '0;
    assign a_sel     = req_a[int'(win)*WIDTH +: WIDTH];
    assign b_sel     = req_b[int'(win)*WIDTH +: WIDTH];
    // Bubbles carry zeros so unused operand inputs never leak into the pipe
    assign sum_s     = xfer ? ({1'b0, a_sel} + {1'b0, b_sel}) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                id_q[i]  <= '0;
                sum_q[i] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= xfer;
            id_q[0]  <= xfer ? win : '0;
            sum_q[0] <= sum_s;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
                sum_q[i] <= sum_q[i-1];
            end
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_sum   = sum_q[LAT-1];
    assign rsp_id    = id_q[LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | vld_q[i];
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_adder_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LAT   = 2;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [WIDTH:0]        rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int p, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: in-flight results as a queue, aged by counting advancing edges
    typedef struct {
        int     id;
        int     sum;
        longint t;
    } item_t;

    item_t  q[$];
    int     ptr_m = 0;
    longint advc  = 0;

    initial begin
        logic            rspv_e, adv_e;
        int              w;
        logic [NREQ-1:0] rdy_e;
        item_t           it;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                q.delete();
                ptr_m = 0;
                advc  = 0;
                w = first_from(0, req_valid);
                rdy_e = (w >= 0) ? (NREQ'(1) << w) : '0;
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_rsp_sum", 32'(rsp_sum), 0);
                chk("rst_rsp_id", 32'(rsp_id), 0);
                chk("rst_req_ready", 32'(req_ready), 32'(rdy_e));
            end else begin
                rspv_e = (q.size() > 0) && (advc - q[0].t == LAT - 1);
                adv_e  = !rspv_e || rsp_ready;
                w      = adv_e ? first_from(ptr_m, req_valid) : -1;
                rdy_e  = (w >= 0) ? (NREQ'(1) << w) : '0;
                chk("rsp_valid", 32'(rsp_valid), 32'(rspv_e));
                chk("busy", 32'(busy), 32'(q.size() > 0));
                chk("req_ready", 32'(req_ready), 32'(rdy_e));
                if (rspv_e) begin
                    chk("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
                    chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                end
                if (rspv_e && rsp_ready) void'(q.pop_front());
                if (adv_e) advc++;
                if (w >= 0) begin
                    it.id  = w;
                    it.sum = int'(req_a[w*WIDTH +: WIDTH]) + int'(req_b[w*WIDTH +: WIDTH]);
                    it.t   = advc;
                    q.push_back(it);
                    ptr_m = (w + 1) % NREQ;
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = '0;
        end
    endtask

    initial begin
        req_a = $urandom;
        req_b = $urandom;
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("T0_valid", 32'(rsp_valid), 0);
        chk("T0_busy", 32'(busy), 0);

        // T1: single transfer from requester 2
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b0100;
        req_a[2*WIDTH +: WIDTH] = 8'd3;
        req_b[2*WIDTH +: WIDTH] = 8'd4;
        #3 chk("T1_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        #3 chk("T1_not_yet", 32'(rsp_valid), 0);
        @(negedge clk);
        #3;
        chk("T1_valid", 32'(rsp_valid), 1);
        chk("T1_sum", 32'(rsp_sum), 7);
        chk("T1_id", 32'(rsp_id), 2);

        // T5: carry and zero sums
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 8'hFF;
        req_b[1*WIDTH +: WIDTH] = 8'h01;
        @(negedge clk);
        req_valid = 4'b0001;
        req_a[0 +: WIDTH] = 8'h00;
        req_b[0 +: WIDTH] = 8'h00;
        @(negedge clk);
        req_valid = '0;
        #3;
        chk("T5_carry_sum", 32'(rsp_sum), 32'h100);
        chk("T5_carry_id", 32'(rsp_id), 1);
        @(negedge clk);
        #3;
        chk("T5_zero_valid", 32'(rsp_valid), 1);
        chk("T5_zero_sum", 32'(rsp_sum), 0);
        idle(3);

        // T3: pointer moves to 2 after granting 1, then 1010 alternates 3,1,3
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b1010;
        #3 chk("T3_g0", 32'(req_ready), 32'h8);
        @(negedge clk);
        #3 chk("T3_g1", 32'(req_ready), 32'h2);
        @(negedge clk);
        #3 chk("T3_g2", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0010;
        #3 chk("T3_g3", 32'(req_ready), 32'h2);
        @(negedge clk);
        #3 chk("T3_g4", 32'(req_ready), 32'h2);
        idle(4);

        // T4: full pipeline stalled for 5 cycles then drained
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            req_a = $urandom;
            req_b = $urandom;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_a = $urandom;
            req_b = $urandom;
            #3 chk("T4_stall_ready", 32'(req_ready), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        idle(5);

        // T6: reset with results in flight while stalled, then fresh rotation (T2)
        @(negedge clk);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        idle(0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #3;
        chk("T6_busy_pre", 32'(busy), 1);
        chk("T6_valid_pre", 32'(rsp_valid), 1);
        @(negedge clk);
        reset = 1'b1;
        #3;
        chk("T6_valid_async", 32'(rsp_valid), 0);
        chk("T6_busy_async", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        #3 chk("T2_g0", 32'(req_ready), 32'h1);
        @(negedge clk);
        #3 chk("T2_g1", 32'(req_ready), 32'h2);
        @(negedge clk);
        #3 chk("T2_g2", 32'(req_ready), 32'h4);
        @(negedge clk);
        #3 chk("T2_g3", 32'(req_ready), 32'h8);
        @(negedge clk);
        #3 chk("T2_g4", 32'(req_ready), 32'h1);
        idle(4);

        // Randomized traffic with random backpressure and rare resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            req_a     = $urandom;
            req_b     = $urandom;
        end
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        idle(6);
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
